gcd_operand_feeder: RTL and testbench
=====================================

GCD_OPERAND_FEEDER -- requirements
Module: gcd_operand_feeder

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width.
REQ-002 Parameter: TIMEOUT, 70000, max WAIT cycles before abort (fits 17-bit counter).
REQ-003 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: op_a / op_b  input  WIDTH  operand pair, sampled on input handshake.
REQ-006 Port: in_valid / in_ready  input / output  1  upstream handshake; transfer when both high at posedge.
REQ-007 Port: gcd_start  output  1  start pulse to subtractive GCD core.
REQ-008 Port: gcd_data  output  WIDTH  operand bus to core (core's data_in).
REQ-009 Port: gcd_done / gcd_result  input  1 / WIDTH  core completion flag and core A-register value.
REQ-010 Port: res_gcd  output  WIDTH  result value.
REQ-011 Port: res_err  output  1  result invalid (both operands zero, or timeout).
REQ-012 Port: res_cycles  output  17  cycles spent in WAIT for this job (0 for bypass).
REQ-013 Port: res_valid / res_ready  output / input  1  downstream handshake.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_A, LOAD_B, WAIT, RESP; reset state IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; one job in flight at a time.
REQ-016 On transfer in IDLE with op_a!=0 and op_b!=0: latch operands, next state LOAD_A.
REQ-017 On transfer with op_a==0 xor op_b==0: bypass core, next state RESP, res_gcd = nonzero operand, res_err=0, res_cycles=0.
REQ-018 On transfer with op_a==0 and op_b==0: next state RESP, res_gcd=0, res_err=1, res_cycles=0.
REQ-019 LOAD_A (1 cycle): gcd_start=1, gcd_data=latched A; next LOAD_B.
REQ-020 LOAD_B (1 cycle): gcd_start=0, gcd_data=latched B; next WAIT.
REQ-021 gcd_start SHALL be high only in LOAD_A; gcd_data SHALL be 0 outside LOAD_A/LOAD_B.
REQ-022 WAIT: 17-bit counter starts at 0 on entry, increments every WAIT cycle, saturates at TIMEOUT.
REQ-023 Done qualification: gcd_done is accepted only after gcd_done was sampled low at least once in the current WAIT; a stale high from the previous job SHALL be ignored.
REQ-024 On qualified gcd_done=1: capture gcd_result into res_gcd, res_err=0, res_cycles=counter; next RESP.
REQ-025 If counter reaches TIMEOUT without qualified done: res_gcd=0, res_err=1, res_cycles=TIMEOUT; next RESP.
REQ-026 Qualified done and timeout in the same cycle: done wins (res_err=0).
REQ-027 RESP: res_valid=1; res_gcd/res_err/res_cycles SHALL be held stable while res_valid=1 and res_ready=0.
REQ-028 RESP with res_ready=1: next IDLE; res_valid falls the following cycle; in_ready rises the same cycle.
REQ-029 Result for nonzero operands SHALL equal the core's value; feeder performs no arithmetic on it.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, in_ready=1 after release, gcd_start=0, gcd_data=0, res_valid=0, res_gcd=0, res_err=0, res_cycles=0, counter=0.
REQ-031 Reset in any state (incl. mid-WAIT) SHALL abort the job with no result emitted; first posedge after release operates from IDLE.
REQ-032 in_valid during reset SHALL not be accepted.

Verification
REQ-033 op_a=143, op_b=78, core model -> gcd_start pulse 1 cycle with gcd_data=143, next cycle gcd_data=78; res_gcd=13, res_err=0.
REQ-034 op_a=0, op_b=25 -> no gcd_start; res_valid one cycle after transfer, res_gcd=25, res_cycles=0, res_err=0.
REQ-035 op_a=0, op_b=0 -> res_gcd=0, res_err=1, no gcd_start.
REQ-036 gcd_done held high throughout (stale) with TIMEOUT=20 -> no early capture; res_err=1, res_cycles=20.
REQ-037 res_ready=0 for 5 cycles in RESP -> res_valid and result fields stable, in_ready=0; completes on res_ready=1.
REQ-038 reset_n pulsed low mid-WAIT -> outputs at reset values immediately; subsequent 48,18 job returns res_gcd=6.

Source files
------------

// File: rtl/gcd_operand_feeder.sv
// Operand feeder for a subtractive GCD core.
// Accepts one operand pair at a time, handles the zero-operand cases locally,
// otherwise loads A then B into the core, waits for a fresh done with a
// bounded cycle counter, and holds the result until the consumer takes it.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a new operand pair
// LOAD_A | start pulse to core, A on the data bus
// LOAD_B | B on the data bus
// WAIT   | counting cycles until a qualified done or timeout
// RESP   | result presented, waiting for res_ready
module gcd_operand_feeder #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 70000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
    output logic [16:0]      res_cycles,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

    state_t           r_state;
    logic [WIDTH-1:0] r_op_b;
    logic [16:0]      r_cnt;
    // Set once done has been seen low in this WAIT; a high left over from
    // the previous job must not be taken as completion of this one.
    logic             r_seen_low;
    logic             r_gcd_start;
    logic [WIDTH-1:0] r_gcd_data;
    logic [WIDTH-1:0] r_res_gcd;
    logic             r_res_err;
    logic [16:0]      r_res_cycles;
    logic             r_res_valid;

    logic w_take;
    logic w_a_zero;
    logic w_b_zero;
    logic w_done_q;
    logic w_timeout;

    // Handshake and qualification terms
    always_comb begin
        w_take    = in_valid && (r_state == IDLE);
        w_a_zero  = (op_a == '0);
        w_b_zero  = (op_b == '0);
        w_done_q  = gcd_done && r_seen_low;
        w_timeout = (r_cnt == TIMEOUT_CNT);
    end

    // Sequencer with all outputs registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_op_b       <= '0;
            r_cnt        <= '0;
            r_seen_low   <= 1'b0;
            r_gcd_start  <= 1'b0;
            r_gcd_data   <= '0;
            r_res_gcd    <= '0;
            r_res_err    <= 1'b0;
            r_res_cycles <= '0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        if (!w_a_zero && !w_b_zero) begin
                            r_gcd_start <= 1'b1;
                            r_gcd_data  <= op_a;
                            r_op_b      <= op_b;
                            r_state     <= LOAD_A;
                        end else begin
                            // gcd(x,0)=x; gcd(0,0) is undefined and flagged
                            r_res_gcd    <= w_a_zero ? op_b : op_a;
                            r_res_err    <= w_a_zero && w_b_zero;
                            r_res_cycles <= '0;
                            r_res_valid  <= 1'b1;
                            r_state      <= RESP;
                        end
                    end
                end
                LOAD_A: begin
                    r_gcd_start <= 1'b0;
                    r_gcd_data  <= r_op_b;
                    r_state     <= LOAD_B;
                end
                LOAD_B: begin
                    r_gcd_data <= '0;
                    r_cnt      <= '0;
                    r_seen_low <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (w_done_q) begin
                        r_res_gcd    <= gcd_result;
                        r_res_err    <= 1'b0;
                        r_res_cycles <= r_cnt;
                        r_res_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_res_gcd    <= '0;
                        r_res_err    <= 1'b1;
                        r_res_cycles <= TIMEOUT_CNT;
                        r_res_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                        if (!gcd_done) begin
                            r_seen_low <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign gcd_start  = r_gcd_start;
    assign gcd_data   = r_gcd_data;
    assign res_gcd    = r_res_gcd;
    assign res_err    = r_res_err;
    assign res_cycles = r_res_cycles;
    assign res_valid  = r_res_valid;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a behavioural subtractive GCD core.
module tb_gcd_operand_feeder;

    logic        clk;
    logic        rst_n;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        in_valid;
    logic        in_ready;
    logic        gcd_start;
    logic [15:0] gcd_data;
    logic        gcd_done;
    logic [15:0] gcd_result;
    logic [15:0] res_gcd;
    logic        res_err;
    logic [16:0] res_cycles;
    logic        res_valid;
    logic        res_ready;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int n;

    logic [15:0] ca;
    logic [15:0] cb;
    logic [1:0]  ph;
    logic        core_done;
    logic        force_done;

    gcd_operand_feeder #(.WIDTH(16), .TIMEOUT(20)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gcd_start  (gcd_start),
        .gcd_data   (gcd_data),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .res_gcd    (res_gcd),
        .res_err    (res_err),
        .res_cycles (res_cycles),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: A on start, B next cycle, one subtraction per cycle; done
    // stays high until the next start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 2'd0; core_done <= 1'b0; ca <= '0; cb <= '0;
        end else if (gcd_start) begin
            ca <= gcd_data; ph <= 2'd1; core_done <= 1'b0;
        end else if (ph == 2'd1) begin
            cb <= gcd_data; ph <= 2'd2;
        end else if (ph == 2'd2) begin
            if (ca == cb) begin
                core_done <= 1'b1; ph <= 2'd0;
            end else if (ca > cb) begin
                ca <= ca - cb;
            end else begin
                cb <= cb - ca;
            end
        end
    end

    assign gcd_done   = force_done | core_done;
    assign gcd_result = ca;

    always @(posedge clk) begin
        if (gcd_start) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int limit, output int cnt);
        cnt = 0;
        while (!res_valid && cnt < limit) begin
            tick();
            cnt++;
        end
        check("res_valid_seen", 32'(res_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; op_a = '0; op_b = '0; in_valid = 1'b0;
        res_ready = 1'b0; force_done = 1'b0;
        #1;
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_res_valid",  32'(res_valid), 32'd0);
        check("rst_gcd_start",  32'(gcd_start), 32'd0);
        check("rst_gcd_data",   32'(gcd_data), 32'd0);
        check("rst_res_gcd",    32'(res_gcd), 32'd0);
        check("rst_res_err",    32'(res_err), 32'd0);
        check("rst_res_cycles", 32'(res_cycles), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // 143,78 through the core: gcd 13, done qualified 7 WAIT cycles in
        op_a = 16'd143; op_b = 16'd78; in_valid = 1'b1;
        check("j1_in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("j1_start_hi",   32'(gcd_start), 32'd1);
        check("j1_data_a",     32'(gcd_data), 32'd143);
        check("j1_in_ready_busy", 32'(in_ready), 32'd0);
        tick();
        check("j1_start_lo",   32'(gcd_start), 32'd0);
        check("j1_data_b",     32'(gcd_data), 32'd78);
        tick();
        check("j1_data_zero",  32'(gcd_data), 32'd0);
        wait_res(40, n);
        check("j1_latency",    32'(n), 32'd8);
        check("j1_res_gcd",    32'(res_gcd), 32'd13);
        check("j1_res_err",    32'(res_err), 32'd0);
        check("j1_res_cycles", 32'(res_cycles), 32'd7);
        check("j1_one_start",  32'(start_cnt), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("j1_valid_fall", 32'(res_valid), 32'd0);
        check("j1_ready_rise", 32'(in_ready), 32'd1);

        // 0,25 bypass: result one cycle after transfer
        op_a = 16'd0; op_b = 16'd25; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("byp_valid",   32'(res_valid), 32'd1);
        check("byp_gcd",     32'(res_gcd), 32'd25);
        check("byp_cycles",  32'(res_cycles), 32'd0);
        check("byp_err",     32'(res_err), 32'd0);
        check("byp_nostart", 32'(start_cnt), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset in WAIT aborts the job; in_valid under reset is ignored
        op_a = 16'd100; op_b = 16'd75; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("rw_started", 32'(start_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rw_res_gcd",   32'(res_gcd), 32'd0);
        check("rw_res_valid", 32'(res_valid), 32'd0);
        check("rw_res_err",   32'(res_err), 32'd0);
        check("rw_cycles",    32'(res_cycles), 32'd0);
        check("rw_gcd_data",  32'(gcd_data), 32'd0);
        check("rw_in_ready",  32'(in_ready), 32'd1);
        op_a = 16'd48; op_b = 16'd18; in_valid = 1'b1;
        tick(); tick();
        check("rw_no_accept", 32'(start_cnt), 32'd2);
        check("rw_start_lo",  32'(gcd_start), 32'd0);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        check("j48_start", 32'(gcd_start), 32'd1);
        check("j48_data",  32'(gcd_data), 32'd48);
        wait_res(40, n);
        check("j48_gcd",    32'(res_gcd), 32'd6);
        check("j48_err",    32'(res_err), 32'd0);
        check("j48_cycles", 32'(res_cycles), 32'd5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 9,0 bypass held 5 cycles by res_ready=0, new request pending
        op_a = 16'd9; op_b = 16'd0; in_valid = 1'b1;
        tick();
        op_a = 16'd0; op_b = 16'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("st_valid",    32'(res_valid), 32'd1);
            check("st_gcd",      32'(res_gcd), 32'd9);
            check("st_err",      32'(res_err), 32'd0);
            check("st_cycles",   32'(res_cycles), 32'd0);
            check("st_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("st_valid_fall", 32'(res_valid), 32'd0);
        check("st_ready_rise", 32'(in_ready), 32'd1);

        // Pending 0,0 accepted now: error result, no core start
        tick();
        in_valid = 1'b0;
        check("zz_valid",   32'(res_valid), 32'd1);
        check("zz_gcd",     32'(res_gcd), 32'd0);
        check("zz_err",     32'(res_err), 32'd1);
        check("zz_cycles",  32'(res_cycles), 32'd0);
        check("zz_nostart", 32'(start_cnt), 32'd3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Done stuck high: never qualified, times out after 20 WAIT cycles
        force_done = 1'b1;
        op_a = 16'd10; op_b = 16'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_res(60, n);
        check("to_latency", 32'(n), 32'd23);
        check("to_gcd",     32'(res_gcd), 32'd0);
        check("to_err",     32'(res_err), 32'd1);
        check("to_cycles",  32'(res_cycles), 32'd20);
        force_done = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("to_idle", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
